// File: rtl/staff_fb_write_arbiter_pkg.sv
// Shared types and frame-buffer geometry for the staff frame-buffer write arbiter.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_CLEAR
   } arb_state_t;

   localparam int          FB_WIDTH    = 320;
   localparam int          FB_HEIGHT   = 180;
   localparam int          FB_DEPTH    = FB_WIDTH * FB_HEIGHT;
   localparam logic [15:0] CLEAR_COLOR = 16'h00FF;

endpackage

// File: rtl/staff_fb_write_arbiter_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, as one-hot and index.
module rr_priority_picker #(
   parameter int N = 3,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx
);

   int k;

   // Scan from the far end so the closest candidate to ptr is written last and wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      k      = 0;
      for (int i = N - 1; i >= 0; i--) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (valid[k]) begin
            onehot    = '0;
            onehot[k] = 1'b1;
            idx       = W'(k);
         end
      end
   end

endmodule

// File: rtl/staff_fb_write_arbiter.sv
// Shares the staff frame-buffer write port between pixel producers with burst-locked
// round-robin arbitration and a built-in full-screen clear sequencer.
module staff_fb_write_arbiter #(
   parameter int                NUM_REQ     = 3,
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter int                FB_DEPTH    = fb_arb_pkg::FB_DEPTH,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(fb_arb_pkg::CLEAR_COLOR),
   localparam int               GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   input  logic [NUM_REQ-1:0]             req_last_in,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   input  logic                           clear_req_in,
   output logic                           clear_busy_out,
   output logic                           clear_done_out,
   output logic                           fb_we_out,
   output logic [ADDR_W-1:0]              fb_addr_out,
   output logic [DATA_W-1:0]              fb_data_out,
   output logic [GW-1:0]                  grant_out,
   output logic                           drop_flag_out
);

   import fb_arb_pkg::*;

   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
   localparam logic [GW-1:0]     LAST_REQ  = GW'(NUM_REQ - 1);

   arb_state_t         state;
   logic [GW-1:0]      rr_ptr;
   logic               pending;
   logic [ADDR_W-1:0]  clr_cnt;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [GW-1:0]      pick_idx;
   logic               accept, accept_last, in_range, clear_now;

   rr_priority_picker #(.N(NUM_REQ), .W(GW)) u_pick (
      .valid  (req_valid_in),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   always_comb begin
      req_ready_out = '0;
      if (state == ST_SERVE) req_ready_out[grant_out] = 1'b1;
   end

   assign accept         = (state == ST_SERVE) && req_valid_in[grant_out];
   assign accept_last    = accept && req_last_in[grant_out];
   assign in_range       = {1'b0, req_addr_in[grant_out]} < DEPTH_X;
   assign clear_now      = pending | clear_req_in;
   assign clear_busy_out = pending | (state == ST_CLEAR);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= ST_IDLE;
         rr_ptr         <= '0;
         grant_out      <= '0;
         pending        <= 1'b0;
         clr_cnt        <= '0;
         fb_we_out      <= 1'b0;
         fb_addr_out    <= '0;
         fb_data_out    <= '0;
         clear_done_out <= 1'b0;
         drop_flag_out  <= 1'b0;
      end else begin
         fb_we_out      <= 1'b0;
         clear_done_out <= 1'b0;
         if (state != ST_CLEAR && clear_req_in) pending <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (clear_now) begin
                  state   <= ST_CLEAR;
                  pending <= 1'b0;
                  clr_cnt <= '0;
               end else if (|pick_onehot) begin
                  grant_out <= pick_idx;
                  state     <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (accept) begin
                  fb_addr_out <= req_addr_in[grant_out];
                  fb_data_out <= req_data_in[grant_out];
                  fb_we_out   <= in_range;
                  if (!in_range) drop_flag_out <= 1'b1;
               end
               if (accept_last) begin
                  rr_ptr <= (grant_out == LAST_REQ) ? '0 : grant_out + 1'b1;
                  if (clear_now) begin
                     state   <= ST_CLEAR;
                     pending <= 1'b0;
                     clr_cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_CLEAR: begin
               // Stay one extra cycle while the final write is on the port so busy covers done.
               if (clear_done_out) begin
                  state <= ST_IDLE;
               end else begin
                  fb_we_out   <= 1'b1;
                  fb_addr_out <= clr_cnt;
                  fb_data_out <= CLEAR_COLOR;
                  if (clr_cnt == LAST_ADDR) clear_done_out <= 1'b1;
                  else                      clr_cnt        <= clr_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_staff_fb_write_arbiter.sv
// Directed bench for staff_fb_write_arbiter with a cycle-level behavioural model.
module tb_staff_fb_write_arbiter;

   localparam int N = 3, AW = 16, DW = 16, DEPTH = 57600;

   logic                   clk_in = 1'b0;
   logic                   rst_in;
   logic [N-1:0]           req_valid_in, req_last_in, req_ready_out;
   logic [N-1:0][AW-1:0]   req_addr_in;
   logic [N-1:0][DW-1:0]   req_data_in;
   logic                   clear_req_in, clear_busy_out, clear_done_out, fb_we_out;
   logic [AW-1:0]          fb_addr_out;
   logic [DW-1:0]          fb_data_out;
   logic [1:0]             grant_out;
   logic                   drop_flag_out;

   logic          v [N];
   logic          l [N];
   logic [AW-1:0] a [N];
   logic [DW-1:0] d [N];

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign req_valid_in[g] = v[g];
      assign req_last_in[g]  = l[g];
      assign req_addr_in[g]  = a[g];
      assign req_data_in[g]  = d[g];
   end

   staff_fb_write_arbiter dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .req_valid_in   (req_valid_in),
      .req_last_in    (req_last_in),
      .req_addr_in    (req_addr_in),
      .req_data_in    (req_data_in),
      .req_ready_out  (req_ready_out),
      .clear_req_in   (clear_req_in),
      .clear_busy_out (clear_busy_out),
      .clear_done_out (clear_done_out),
      .fb_we_out      (fb_we_out),
      .fb_addr_out    (fb_addr_out),
      .fb_data_out    (fb_data_out),
      .grant_out      (grant_out),
      .drop_flag_out  (drop_flag_out)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 serving owner, 2 clearing (cnt==DEPTH is the done cycle).
   int  m_mode, m_owner, m_ptr, m_cnt, e_addr, e_data;
   bit  m_pend, m_drop, e_we, e_done, go_clear, found;

   always @(posedge clk_in) begin
      if (rst_in) begin
         m_mode = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_pend = 0; m_drop = 0;
         e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
      end else begin
         go_clear = m_pend || clear_req_in;
         e_we = 0;
         e_done = 0;
         if (m_mode == 2) begin
            if (m_cnt == DEPTH) m_mode = 0;
            else begin
               e_we = 1; e_addr = m_cnt; e_data = 'h00FF;
               e_done = (m_cnt == DEPTH - 1);
               m_cnt++;
            end
         end else begin
            if (clear_req_in) m_pend = 1;
            if (m_mode == 0) begin
               if (go_clear) begin
                  m_mode = 2; m_pend = 0; m_cnt = 0;
               end else if (req_valid_in != 0) begin
                  found = 0;
                  for (int j = 0; j < N; j++)
                     if (!found && req_valid_in[(m_ptr + j) % N]) begin
                        m_owner = (m_ptr + j) % N;
                        found = 1;
                     end
                  m_mode = 1;
               end
            end else if (req_valid_in[m_owner]) begin
               if (int'(req_addr_in[m_owner]) < DEPTH) begin
                  e_we = 1; e_addr = req_addr_in[m_owner]; e_data = req_data_in[m_owner];
               end else m_drop = 1;
               if (req_last_in[m_owner]) begin
                  m_ptr = (m_owner + 1) % N;
                  if (go_clear) begin
                     m_mode = 2; m_pend = 0; m_cnt = 0;
                  end else m_mode = 0;
               end
            end
         end
      end
   end

   always @(posedge clk_in) begin
      #2;
      check("ready", req_ready_out, (m_mode == 1) ? (1 << m_owner) : 0);
      check("fb_we", fb_we_out, e_we);
      if (e_we) begin
         check("fb_addr", fb_addr_out, e_addr);
         check("fb_data", fb_data_out, e_data);
      end
      check("clear_done", clear_done_out, e_done);
      check("clear_busy", clear_busy_out, m_pend || m_mode == 2);
      check("drop_flag", drop_flag_out, m_drop);
      check("grant", grant_out, m_owner);
   end

   int dq[$];
   int n_clr = 0, n_done = 0;
   bit hit1000 = 0;

   always @(posedge clk_in) begin
      #2;
      if (fb_we_out) begin
         dq.push_back(int'(fb_addr_out));
         if (fb_data_out == 16'h00FF) n_clr++;
         if (fb_addr_out == 16'd1000 && fb_data_out == 16'h00FF) hit1000 = 1;
      end
      if (clear_done_out) n_done++;
   end

   function automatic int qat(input int i);
      return (i >= 0 && i < dq.size()) ? dq[i] : -1;
   endfunction

   task automatic burst(input int r, input int base, input int n, input int stall_at,
                        input int stall_len);
      int i = 0;
      int budget = 0;
      bit stalled = 0;
      while (i < n && budget < 500) begin
         @(negedge clk_in);
         if (i == stall_at && !stalled) begin
            v[r] = 1'b0;
            l[r] = 1'b0;
            repeat (stall_len) @(negedge clk_in);
            stalled = 1;
         end
         v[r] = 1'b1;
         a[r] = AW'(base + i);
         d[r] = DW'(r * 4096 + i);
         l[r] = (i == n - 1);
         if (req_ready_out[r]) i++;
         budget++;
      end
      if (i < n) begin
         n_chk++;
         n_fail++;
         $display("FAIL burst%0d_timeout: accepted %0d of %0d beats", r, i, n);
      end
      @(negedge clk_in);
      v[r] = 1'b0;
      l[r] = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         v[i] = 0; l[i] = 0; a[i] = '0; d[i] = '0;
      end
      rst_in = 1'b1;
      clear_req_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_fb_we", fb_we_out, 0);
      check("rst_fb_addr", fb_addr_out, 0);
      check("rst_fb_data", fb_data_out, 0);
      check("rst_ready", req_ready_out, 0);
      check("rst_busy", clear_busy_out, 0);
      check("rst_done", clear_done_out, 0);
      check("rst_drop", drop_flag_out, 0);
      check("rst_grant", grant_out, 0);
      rst_in = 1'b0;

      // Single requester, 35-beat burst
      dq.delete();
      burst(0, 24000, 35, -1, 0);
      repeat (3) @(negedge clk_in);
      check("t1_count", dq.size(), 35);
      check("t1_first", qat(0), 24000);
      check("t1_last", qat(34), 24034);
      check("t1_ready_idle", req_ready_out, 0);

      // Contention from rr_ptr=0, then pointer must sit at 2
      pulse_reset();
      dq.delete();
      fork
         burst(0, 1000, 4, -1, 0);
         burst(1, 2000, 4, -1, 0);
      join
      repeat (3) @(negedge clk_in);
      check("t2_count", dq.size(), 8);
      check("t2_r0_first", qat(0), 1000);
      check("t2_r0_last", qat(3), 1003);
      check("t2_r1_first", qat(4), 2000);
      check("t2_r1_last", qat(7), 2003);
      dq.delete();
      fork
         burst(0, 3000, 1, -1, 0);
         burst(2, 3100, 1, -1, 0);
      join
      repeat (3) @(negedge clk_in);
      check("t2_ptr2_wins", qat(0), 3100);
      check("t2_then_r0", qat(1), 3000);

      // Mid-burst stall on req1 while req2 waits
      dq.delete();
      fork
         burst(1, 4000, 6, 3, 5);
         begin
            repeat (2) @(negedge clk_in);
            burst(2, 5000, 4, -1, 0);
         end
      join
      repeat (3) @(negedge clk_in);
      check("t3_count", dq.size(), 10);
      check("t3_pre_stall", qat(2), 4002);
      check("t3_post_stall", qat(3), 4003);
      check("t3_r1_last", qat(5), 4005);
      check("t3_r2_after", qat(6), 5000);

      // Clear requested during a burst
      dq.delete();
      n_clr = 0;
      n_done = 0;
      fork
         burst(0, 6000, 8, -1, 0);
         begin
            repeat (3) @(negedge clk_in);
            clear_req_in = 1'b1;
            @(negedge clk_in);
            clear_req_in = 1'b0;
         end
      join
      for (int c = 0; c < 60000 && n_done == 0; c++) @(negedge clk_in);
      repeat (3) @(negedge clk_in);
      check("t4_done_count", n_done, 1);
      check("t4_clear_writes", n_clr, 57600);
      check("t4_total_writes", dq.size(), 57608);
      check("t4_burst_last", qat(7), 6007);
      check("t4_clear_first", qat(8), 0);
      check("t4_clear_last", qat(57607), 57599);
      check("t4_busy_after", clear_busy_out, 0);

      // Out-of-range beat
      dq.delete();
      burst(0, 57599, 2, -1, 0);
      repeat (3) @(negedge clk_in);
      check("t5_count", dq.size(), 1);
      check("t5_in_range", qat(0), 57599);
      check("t5_drop", drop_flag_out, 1);
      burst(1, 7000, 2, -1, 0);
      repeat (3) @(negedge clk_in);
      check("t5_drop_sticky", drop_flag_out, 1);
      check("t5_after_write", qat(2), 7001);

      // Reset in the middle of a clear
      n_done = 0;
      hit1000 = 0;
      @(negedge clk_in);
      clear_req_in = 1'b1;
      @(negedge clk_in);
      clear_req_in = 1'b0;
      for (int c = 0; c < 3000 && !hit1000; c++) @(negedge clk_in);
      check("t6_reached_1000", hit1000, 1);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("t6_fb_we", fb_we_out, 0);
      check("t6_fb_addr", fb_addr_out, 0);
      check("t6_busy", clear_busy_out, 0);
      check("t6_done", clear_done_out, 0);
      check("t6_drop", drop_flag_out, 0);
      check("t6_ready", req_ready_out, 0);
      rst_in = 1'b0;
      repeat (20) @(negedge clk_in);
      check("t6_no_done", n_done, 0);
      dq.delete();
      burst(2, 8000, 2, -1, 0);
      repeat (3) @(negedge clk_in);
      check("t6_grant", grant_out, 2);
      check("t6_burst_ok", qat(1), 8001);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
